// File: rtl/data_sram_if.sv
// data_sram_if: single-cycle data SRAM request/response bundle between the CPU core and its responder.
interface data_sram_if;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master (output en, we, addr, wdata, input rdata);
  modport slave (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/data_sram_resp.sv
// data_sram_resp: byte-writable RAM plus MMIO window (scratch, timer, access count, status) with 1-cycle read latency.
// Timer register at offset 0x4 exists only when DSRAM_TIMER_EN is defined.
module data_sram_resp #(
  parameter int          ADDR_W  = 14,
  parameter logic [15:0] MMIO_HI = 16'hbfaf
) (
  input  logic        clk,
  input  logic        resetn,
  data_sram_if.slave  bus,
  output logic        oor_err
);
  logic [31:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic [15:0] off;
  logic [31:0] bmask, mmio_rd, timer_rd;
  logic is_mmio, oor, ram_wr, mmio_acc;
  logic [31:0] rdata_q, rdata_d, scratch_q, scratch_d, count_q, count_d;
  logic oor_q, oor_d;
  always_comb begin
    idx      = bus.addr[ADDR_W+1:2];
    off      = bus.addr[15:0] & 16'hfffc;
    is_mmio  = bus.addr[31:16] == MMIO_HI;
    oor      = !is_mmio && ((bus.addr[28:0] >> (ADDR_W + 2)) != '0);
    mmio_acc = bus.en && is_mmio;
    ram_wr   = bus.en && !is_mmio && !oor;
    bmask    = {{8{bus.we[3]}}, {8{bus.we[2]}}, {8{bus.we[1]}}, {8{bus.we[0]}}};
    mmio_rd  = off == 16'h0 ? scratch_q :
               off == 16'h4 ? timer_rd :
               off == 16'h8 ? count_q :
               off == 16'hc ? {31'b0, oor_q} : '0;
    rdata_d   = !bus.en ? rdata_q : is_mmio ? mmio_rd : oor ? '0 : mem[idx];
    scratch_d = (mmio_acc && off == 16'h0) ? (scratch_q & ~bmask) | (bus.wdata & bmask) : scratch_q;
    count_d   = count_q + {31'b0, bus.en};
    // a fresh out-of-range access takes priority over a clear
    oor_d     = (bus.en && oor) ||
                (oor_q && !(mmio_acc && off == 16'hc && bus.we[0] && bus.wdata[0]));
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rdata_q   <= '0;
      scratch_q <= '0;
      count_q   <= '0;
      oor_q     <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      scratch_q <= scratch_d;
      count_q   <= count_d;
      oor_q     <= oor_d;
    end
  // RAM contents survive reset
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (ram_wr && bus.we[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
`ifdef DSRAM_TIMER_EN
  logic [31:0] timer_q, timer_d;
  always_comb timer_d = (mmio_acc && off == 16'h4 && bus.we == 4'hf) ? bus.wdata : timer_q + 32'd1;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) timer_q <= '0;
    else timer_q <= timer_d;
  assign timer_rd = timer_q;
`else
  assign timer_rd = '0;
`endif
  assign bus.rdata = rdata_q;
  assign oor_err   = oor_q;
endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: directed vector table plus hand sequences for timer, hold and async reset.
module tb_data_sram_resp;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic oor_err;
  int errors = 0;
  int checks = 0;
  data_sram_if bus ();
  data_sram_resp #(.ADDR_W(14), .MMIO_HI(16'hbfaf)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .oor_err(oor_err)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] rd;
    logic        oor;
  } vec_t;
  vec_t v[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic req(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.en = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wdata;
    @(posedge clk); #1;
    bus.en = 1'b0;
  endtask

  task automatic idle();
    bus.en = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [31:0] t_exp;
  initial begin
    bus.en = 1'b0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    v[0]  = '{4'hf, 32'hbfaf_0000, 32'hA5A5_A5A5, 1'b1, 32'h0000_0000, 1'b0};
    v[1]  = '{4'h4, 32'hbfaf_0000, 32'h003C_0000, 1'b1, 32'hA5A5_A5A5, 1'b0};
    v[2]  = '{4'h0, 32'hbfaf_0000, 32'h0,         1'b1, 32'hA53C_A5A5, 1'b0};
    v[3]  = '{4'hf, 32'h0000_0100, 32'h1122_3344, 1'b0, 32'h0,         1'b0};
    v[4]  = '{4'h2, 32'h0000_0100, 32'h0000_AA00, 1'b1, 32'h1122_3344, 1'b0};
    v[5]  = '{4'h0, 32'hbfaf_0008, 32'h0,         1'b1, 32'h0000_0005, 1'b0};
    v[6]  = '{4'hf, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0};
    v[7]  = '{4'h0, 32'h0000_0100, 32'h0,         1'b1, 32'h1122_AA44, 1'b0};
    v[8]  = '{4'h0, 32'h0000_0104, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0};
    v[9]  = '{4'h0, 32'hbfaf_0010, 32'h0,         1'b1, 32'h0,         1'b0};
    v[10] = '{4'hf, 32'hbfaf_0010, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b0};
    v[11] = '{4'h0, 32'hbfaf_0008, 32'h0,         1'b1, 32'h0000_000B, 1'b0};
    v[12] = '{4'h0, 32'h0010_0000, 32'h0,         1'b1, 32'h0,         1'b1};
    v[13] = '{4'h0, 32'hbfaf_000c, 32'h0,         1'b1, 32'h0000_0001, 1'b1};
    v[14] = '{4'h1, 32'hbfaf_000c, 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b0};
    v[15] = '{4'h0, 32'hbfaf_000c, 32'h0,         1'b1, 32'h0,         1'b0};
    v[16] = '{4'hf, 32'h0010_0100, 32'h1234_5678, 1'b1, 32'h0,         1'b1};
    v[17] = '{4'h1, 32'hbfaf_000c, 32'h0,         1'b1, 32'h0000_0001, 1'b1};
    v[18] = '{4'h1, 32'hbfaf_000c, 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b0};
    v[19] = '{4'h0, 32'h0010_0100, 32'h0,         1'b1, 32'h0,         1'b1};
    v[20] = '{4'h0, 32'h0000_0100, 32'h0,         1'b1, 32'h1122_AA44, 1'b1};
    v[21] = '{4'h0, 32'hA000_0104, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1};
    v[22] = '{4'hf, 32'h0000_0200, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b1};
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_oor", {31'b0, oor_err}, 32'h0);
    resetn = 1'b1;
    for (int i = 0; i < 23; i++) begin
      req(v[i].we, v[i].addr, v[i].wdata);
      if (v[i].chk_rd) check($sformatf("vec%0d_rdata", i), bus.rdata, v[i].rd);
      check($sformatf("vec%0d_oor", i), {31'b0, oor_err}, {31'b0, v[i].oor});
    end
    // timer: load 0x10, three idle cycles, then read
`ifdef DSRAM_TIMER_EN
    t_exp = 32'h13;
`else
    t_exp = 32'h0;
`endif
    req(4'hf, 32'hbfaf_0004, 32'h0000_0010);
    repeat (3) idle();
    req(4'h0, 32'hbfaf_0004, 32'h0);
    check("timer_load_read", bus.rdata, t_exp);
    req(4'h3, 32'hbfaf_0004, 32'h0);
    req(4'h0, 32'hbfaf_0004, 32'h0);
`ifdef DSRAM_TIMER_EN
    t_exp = 32'h15;
`endif
    check("timer_partial_write_ignored", bus.rdata, t_exp);
    idle();
    check("rdata_hold_idle", bus.rdata, t_exp);
    // async reset asserted mid-cycle with a read in flight
    req(4'hf, 32'hbfaf_0000, 32'h0000_0077);
    bus.en = 1'b1; bus.we = 4'h0; bus.addr = 32'h0000_0200;
    #2 resetn = 1'b0;
    #1;
    check("async_reset_rdata", bus.rdata, 32'h0);
    check("async_reset_oor", {31'b0, oor_err}, 32'h0);
    @(posedge clk); #1;
    bus.en = 1'b0;
    resetn = 1'b1;
    idle();
    check("post_reset_rdata", bus.rdata, 32'h0);
    req(4'h0, 32'hbfaf_0000, 32'h0);
    check("post_reset_scratch", bus.rdata, 32'h0);
    req(4'h0, 32'h0000_0200, 32'h0);
    check("ram_survives_reset", bus.rdata, 32'hCAFE_F00D);
    req(4'h0, 32'hbfaf_0008, 32'h0);
    check("post_reset_count", bus.rdata, 32'h0000_0002);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
